// File: rtl/mux_scan_serializer_pkg.sv
// Shared types and widths for the mux-based scan serializer.
package mux_scan_serializer_pkg;

    localparam int WORD_W = 16;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/s16bitmux.sv
// 16:1 bit-select mux; picks one bit of a 16-bit word by a 4-bit index.
module s16bitmux (
    input  logic [15:0] in,
    input  logic [3:0]  sel,
    output logic        out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_scan_serializer.sv
// Serializes a 16-bit word one bit per accepted transfer by sweeping the
// select of a 16:1 mux over a held copy of the word.
//
// state | meaning
// IDLE  | waiting for load_valid; load_ready high
// SHIFT | presenting hold[sel]; out_valid high, advances on out_ready
module mux_scan_serializer
    import mux_scan_serializer_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic [IDX_W-1:0]  sel,
    output logic              out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              last,
    output logic [CNT_W-1:0]  words
);

    localparam logic [IDX_W-1:0] START_IDX = (MSB_FIRST != 0) ? IDX_W'(WORD_W - 1) : '0;
    localparam logic [IDX_W-1:0] END_IDX   = (MSB_FIRST != 0) ? '0 : IDX_W'(WORD_W - 1);

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  hold_q, hold_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   words_q, words_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sel_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        sel_d      = sel_q;
        words_d    = words_q;
        load_ready = 1'b0;
        out_valid  = 1'b0;
        last       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    hold_d  = in;
                    sel_d   = START_IDX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                last      = (sel_q == END_IDX);
                if (out_ready) begin
                    // final bit leaves sel and hold parked where they ended
                    if (last) begin
                        state_d = IDLE;
                        words_d = words_q + CNT_W'(1);
                    end else if (MSB_FIRST != 0) begin
                        sel_d = sel_q - IDX_W'(1);
                    end else begin
                        sel_d = sel_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    s16bitmux u_mux (
        .in  (hold_q),
        .sel (sel_q),
        .out (out)
    );

    assign sel   = sel_q;
    assign words = words_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: LSB-first and MSB-first instances driven in
// parallel, checked against a vector table, directed sequences and a model.
module tb_mux_scan_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] din = 16'h0;

    logic       lr0, ov0, last0, so0, lr1, ov1, last1, so1;
    logic [3:0] sl0, sl1;
    logic [7:0] wd0, wd1;

    int n_checks = 0;
    int n_errors = 0;

    int m_busy[2], m_word[2], m_k[2], m_sel[2], m_words[2];

    always #5 clk = ~clk;

    mux_scan_serializer #(.MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .in(din), .load_valid(load_valid), .load_ready(lr0),
        .sel(sl0), .out(so0), .out_valid(ov0), .out_ready(out_ready), .last(last0),
        .words(wd0)
    );

    mux_scan_serializer #(.MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .in(din), .load_valid(load_valid), .load_ready(lr1),
        .sel(sl1), .out(so1), .out_valid(ov1), .out_ready(out_ready), .last(last1),
        .words(wd1)
    );

    typedef struct {
        logic       rst;
        logic       lv;
        logic [15:0] din;
        logic       ordy;
        logic       e_lr;
        logic       e_ov;
        logic       e_last;
        logic [3:0] e_sel0;
        logic [3:0] e_sel1;
        logic       e_out0;
        logic       e_out1;
        logic [7:0] e_words;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a word is a queue of 16 positions walked in order; k counts
    // how many bits have already been accepted.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 0; m_word[d] = 0; m_k[d] = 0; m_sel[d] = 0; m_words[d] = 0;
            end else if (m_busy[d] == 0) begin
                if (load_valid) begin
                    m_busy[d] = 1; m_word[d] = int'(din); m_k[d] = 0;
                    m_sel[d]  = (d == 1) ? 15 : 0;
                end
            end else if (out_ready) begin
                if (m_k[d] == 15) begin
                    m_busy[d]  = 0;
                    m_words[d] = (m_words[d] + 1) % 256;
                end else begin
                    m_k[d]   = m_k[d] + 1;
                    m_sel[d] = (d == 1) ? 15 - m_k[d] : m_k[d];
                end
            end
        end
    endtask

    task automatic chk_dut(input int d, input logic a_lr, input logic a_ov, input logic a_last,
                           input logic a_out, input logic [3:0] a_sel, input logic [7:0] a_wd);
        string p;
        p = (d == 0) ? "lsb" : "msb";
        chk({p, " load_ready"}, 32'(a_lr), 32'(m_busy[d] == 0));
        chk({p, " out_valid"}, 32'(a_ov), 32'(m_busy[d] != 0));
        chk({p, " last"}, 32'(a_last), 32'(m_busy[d] != 0 && m_k[d] == 15));
        chk({p, " sel"}, 32'(a_sel), 32'(m_sel[d]));
        chk({p, " out"}, 32'(a_out), 32'((m_word[d] >> m_sel[d]) & 1));
        chk({p, " words"}, 32'(a_wd), 32'(m_words[d]));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk_dut(0, lr0, ov0, last0, so0, sl0, wd0);
        chk_dut(1, lr1, ov1, last1, so1, sl1, wd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; load_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic seq0[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
        logic seq1[16] = '{1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1};
        int   wb, guard, ones, ldr;

        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_word[d] = 0; m_k[d] = 0; m_sel[d] = 0; m_words[d] = 0;
        end

        tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd15, seq0[0], seq1[0], 8'd0};
        for (int i = 2; i <= 16; i++)
            tbl[i] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, (i == 16), 4'(i - 1), 4'(16 - i),
                       seq0[i-1], seq1[i-1], 8'd0};
        tbl[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 4'd0, seq0[15], seq1[15], 8'd1};

        // Reset, one word of A5C3 in both bit orders, then back in IDLE.
        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; load_valid = tbl[i].lv; din = tbl[i].din; out_ready = tbl[i].ordy;
            tick();
            chk($sformatf("tbl%0d load_ready", i), 32'({lr0, lr1}), 32'({tbl[i].e_lr, tbl[i].e_lr}));
            chk($sformatf("tbl%0d out_valid", i), 32'({ov0, ov1}), 32'({tbl[i].e_ov, tbl[i].e_ov}));
            chk($sformatf("tbl%0d last", i), 32'({last0, last1}), 32'({tbl[i].e_last, tbl[i].e_last}));
            chk($sformatf("tbl%0d sel", i), 32'({sl0, sl1}), 32'({tbl[i].e_sel0, tbl[i].e_sel1}));
            chk($sformatf("tbl%0d out", i), 32'({so0, so1}), 32'({tbl[i].e_out0, tbl[i].e_out1}));
            chk($sformatf("tbl%0d words", i), 32'({wd0, wd1}), 32'({tbl[i].e_words, tbl[i].e_words}));
        end

        // Load attempts during SHIFT are ignored.
        load_valid = 1'b1; din = 16'h0000; out_ready = 1'b1;
        tick();
        din = 16'hFFFF;
        ones = 0; ldr = 0;
        for (int j = 0; j < 16; j++) begin
            ones += int'(so0) + int'(so1);
            ldr  += int'(lr0) + int'(lr1);
            tick();
        end
        load_valid = 1'b0;
        chk("ignored load ones", 32'(ones), 32'd0);
        chk("ignored load ready", 32'(ldr), 32'd0);
        chk("ignored load words", 32'(wd0), 32'd2);

        // Stalled word: out_ready 1,0,0,1,...
        wb = int'(wd0);
        load_valid = 1'b1; din = 16'h3C96;
        tick();
        load_valid = 1'b0;
        guard = 0;
        while (m_busy[0] != 0 && guard < 100) begin
            out_ready = ((guard % 4) == 0) || ((guard % 4) == 3);
            tick();
            guard++;
        end
        chk("stall timeout", 32'(guard < 100), 32'd1);
        chk("stall words +1", 32'(wd0), 32'((wb + 1) % 256));
        chk("stall words msb", 32'(wd1), 32'((wb + 1) % 256));

        // Reset at transfer 7 abandons the word.
        do_reset();
        load_valid = 1'b1; din = 16'hBEEF; out_ready = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int j = 0; j < 6; j++) tick();
        rst = 1'b1; load_valid = 1'b1;
        tick();
        rst = 1'b0; load_valid = 1'b0;
        chk("midrst sel", 32'({sl0, sl1}), 32'd0);
        chk("midrst out_valid", 32'({ov0, ov1}), 32'd0);
        chk("midrst out", 32'({so0, so1}), 32'd0);
        chk("midrst words", 32'({wd0, wd1}), 32'd0);

        // 257 back-to-back words: counter wraps at 256.
        for (int w = 1; w <= 257; w++) begin
            load_valid = 1'b1; din = 16'($urandom); out_ready = 1'b1;
            tick();
            load_valid = 1'b0;
            for (int j = 0; j < 16; j++) tick();
            if (w == 256) chk("wrap 256", 32'({wd0, wd1}), 32'd0);
            if (w == 257) chk("wrap 257", 32'({wd0, wd1}), 32'h0101);
        end

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            load_valid = 1'($urandom);
            din        = 16'($urandom);
            out_ready  = 1'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
